vliw_multiport_regfile: RTL and testbench
=========================================

// Module: vliw_multiport_regfile
// PURPOSE
//  Parametrised multi-port register file for the VLIW datapath.
//  Generalises the single- and dual-write-data registers to DEPTH x WIDTH storage,
//  NUM_WR write ports and NUM_RD combinational read ports.
//  Resolves same-address write conflicts by fixed priority and counts them for debug.
//  Sits between decode (read addresses) and writeback (one write port per issue slot).
// PARAMETERS
//  WIDTH     32  data bits per register
//  DEPTH     32  number of registers (power of two)
//  AW        5   address width, must equal log2(DEPTH)
//  NUM_WR    2   write ports (one per VLIW slot)
//  NUM_RD    4   read ports
//  ZERO_REG  1   1: register 0 reads as 0 and ignores writes; 0: register 0 is ordinary
//  CNT_W     16  width of the conflict counter
// PORTS
//  clk          in   1             clock; all state updates on FALLING edge of clk
//  reset        in   1             synchronous, active-high
//  wr_en        in   NUM_WR        per-port write enable
//  wr_addr      in   NUM_WR*AW     port p address = wr_addr[p*AW +: AW]
//  wr_data      in   NUM_WR*WIDTH  port p data = wr_data[p*WIDTH +: WIDTH]
//  rd_addr      in   NUM_RD*AW     port r address = rd_addr[r*AW +: AW]
//  rd_data      out  NUM_RD*WIDTH  port r data, combinational from storage
//  wr_conflict  out  1             registered: a conflict was resolved at the last edge
//  conflict_cnt out  CNT_W         registered saturating count of conflict edges
// BEHAVIOUR
//  - Reset: synchronous, active-high, sampled on the falling edge of clk.
//    On that edge: all registers = 0, wr_conflict = 0, conflict_cnt = 0.
//    Reset overrides any write on the same edge.
//    Every rd_data reads 0 while reset is held.
//  - Write: on each falling edge with reset = 0, for each register a:
//    - write_set(a) = ports p where wr_en[p] = 1 and the port's address = a.
//    - If write_set(a) is non-empty, the register takes the data from the HIGHEST-indexed port in the set.
//    - Ports not in the set are ignored; unaddressed registers hold their value.
//  - ZERO_REG = 1: writes to address 0 are dropped.
//    They do not count as conflicts; rd_data for address 0 is always 0.
//  - Conflict:
//    - A conflict is two or more enabled ports with the same address, excluding the dropped address 0.
//    - wr_conflict <= 1 on any edge with at least one conflict, else 0.
//    - conflict_cnt += 1 per conflicting edge (not per pair).
//    - conflict_cnt saturates at 2^CNT_W - 1; it never wraps.
//  - Read: rd_data port r = storage at that port's address, purely combinational.
//    Zero read latency; a write becomes visible after the falling edge that commits it.
//  - Any number of read ports may alias the same address.
//    A read and a write may target the same address in the same cycle.
//  - Out-of-range addresses are impossible by construction (DEPTH = 2^AW).
//  - Parameter check: elaboration-time error if AW != $clog2(DEPTH), or if NUM_WR < 1 or NUM_RD < 1.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - rd_data forwards same-cycle write data when an enabled write port targets the read address.
//    - The forwarded value is the same highest-index winner that will be committed.
//    - ZERO_REG still forces 0.
//    - This gives write-to-read latency 0.
//  REGFILE_BYPASS_EN undefined:
//    - rd_data shows stored contents only.
//    - This gives write-to-read latency 1 falling edge.
// TESTING
//  1 reset=1 for 2 edges, then read all addresses -> every rd_data = 0, wr_conflict = 0, conflict_cnt = 0.
//  2 wr_en=2'b01, port0 addr 5 data 0xDEADBEEF; next cycle rd_addr0 = 5
//    -> 0xDEADBEEF; all other registers remain 0.
//  3 both ports write addr 7: port0 0x11111111, port1 0x22222222
//    -> reg7 = 0x22222222, wr_conflict = 1, conflict_cnt = 1;
//    next edge with no writes -> wr_conflict = 0, count stays 1.
//  4 ZERO_REG=1: port0 and port1 both write addr 0 with 0xFFFFFFFF
//    -> rd_data(0) = 0, wr_conflict = 0, conflict_cnt unchanged.
//  5 CNT_W=2: 5 consecutive conflicting edges
//    -> conflict_cnt sequence 1, 2, 3, 3, 3 (saturates).
//  6 reg 9 = 0xA, write 0xB to addr 9 while reading addr 9 in the same cycle:
//    - without REGFILE_BYPASS_EN -> 0xA before the edge, 0xB after;
//    - with REGFILE_BYPASS_EN -> 0xB immediately;
//    - in both builds, asserting reset mid-write -> 0 after the edge.

Source files
------------

// File: rtl/vliw_multiport_regfile.sv
// rtl/vliw_multiport_regfile.sv - parametrised multi-port VLIW register file
//
// Purpose:
//    DEPTH x WIDTH register file with NUM_WR write ports and NUM_RD
//    combinational read ports. When several write ports target the same
//    register, the highest-indexed enabled port wins. Every edge that
//    resolves at least one such collision sets wr_conflict and bumps a
//    saturating debug counter. All state updates on the FALLING edge of clk.
//
// Ports:
//    clk          clock; state commits on the falling edge
//    reset        synchronous, active-high; also forces every rd_data to 0
//    wr_en        per-port write enable              [NUM_WR]
//    wr_addr      port p address = [p*AW +: AW]      [NUM_WR*AW]
//    wr_data      port p data = [p*WIDTH +: WIDTH]   [NUM_WR*WIDTH]
//    rd_addr      port r address = [r*AW +: AW]      [NUM_RD*AW]
//    rd_data      port r data, combinational         [NUM_RD*WIDTH]
//    wr_conflict  registered: a conflict was resolved at the last edge
//    conflict_cnt registered saturating count of conflicting edges [CNT_W]
//
// Configuration macro:
//    REGFILE_BYPASS_EN  when defined, reads forward same-cycle write data
//                       (write-to-read latency 0); otherwise reads show
//                       stored contents only (latency 1 falling edge).

module vliw_multiport_regfile #(
   parameter int WIDTH    = 32,
   parameter int DEPTH    = 32,
   parameter int AW       = 5,
   parameter int NUM_WR   = 2,
   parameter int NUM_RD   = 4,
   parameter int ZERO_REG = 1,
   parameter int CNT_W    = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_WR-1:0]       wr_en,
   input  logic [NUM_WR*AW-1:0]    wr_addr,
   input  logic [NUM_WR*WIDTH-1:0] wr_data,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   output logic                    wr_conflict,
   output logic [CNT_W-1:0]        conflict_cnt
);

   if (AW != $clog2(DEPTH)) begin : g_bad_aw
      $error("vliw_multiport_regfile: AW must equal $clog2(DEPTH)");
   end
   if (NUM_WR < 1 || NUM_RD < 1) begin : g_bad_ports
      $error("vliw_multiport_regfile: NUM_WR and NUM_RD must be at least 1");
   end

   logic [WIDTH-1:0] mem_q  [DEPTH];
   logic [WIDTH-1:0] mem_d  [DEPTH];
   logic [AW-1:0]    wa     [NUM_WR];
   logic [WIDTH-1:0] wd     [NUM_WR];
   logic [AW-1:0]    ra     [NUM_RD];
   logic [WIDTH-1:0] rd_val [NUM_RD];
   logic [NUM_WR-1:0] wr_keep;
   logic              conflict_d, wr_conflict_q;
   logic [CNT_W-1:0]  cnt_d, cnt_q;

   for (genvar p = 0; p < NUM_WR; p++) begin : g_wr_unpack
      assign wa[p] = wr_addr[p*AW +: AW];
      assign wd[p] = wr_data[p*WIDTH +: WIDTH];
   end
   for (genvar r = 0; r < NUM_RD; r++) begin : g_rd_unpack
      assign ra[r] = rd_addr[r*AW +: AW];
      assign rd_data[r*WIDTH +: WIDTH] = rd_val[r];
   end

   // A port takes part in writes and conflicts only if enabled and not
   // aimed at the hard-wired zero register.
   always_comb begin
      for (int p = 0; p < NUM_WR; p++) begin
         wr_keep[p] = wr_en[p] && !(ZERO_REG != 0 && wa[p] == '0);
      end
   end

   // Ascending port order: later assignments override, so the highest
   // enabled port to an address wins.
   always_comb begin
      mem_d = mem_q;
      for (int p = 0; p < NUM_WR; p++) begin
         if (wr_keep[p]) begin
            mem_d[wa[p]] = wd[p];
         end
      end
   end

   always_comb begin
      conflict_d = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
         for (int q = p + 1; q < NUM_WR; q++) begin
            if (wr_keep[p] && wr_keep[q] && wa[p] == wa[q]) begin
               conflict_d = 1'b1;
            end
         end
      end
   end

   // One increment per conflicting edge, held at all-ones once reached.
   always_comb begin
      cnt_d = cnt_q;
      if (conflict_d && cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_comb begin
      for (int r = 0; r < NUM_RD; r++) begin
         rd_val[r] = mem_q[ra[r]];
`ifdef REGFILE_BYPASS_EN
         for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && wa[p] == ra[r]) begin
               rd_val[r] = wd[p];
            end
         end
`endif
         if (ZERO_REG != 0 && ra[r] == '0) begin
            rd_val[r] = '0;
         end
         if (reset) begin
            rd_val[r] = '0;
         end
      end
   end

   always_ff @(negedge clk) begin
      if (reset) begin
         for (int a = 0; a < DEPTH; a++) begin
            mem_q[a] <= '0;
         end
         wr_conflict_q <= 1'b0;
         cnt_q         <= '0;
      end else begin
         for (int a = 0; a < DEPTH; a++) begin
            mem_q[a] <= mem_d[a];
         end
         wr_conflict_q <= conflict_d;
         cnt_q         <= cnt_d;
      end
   end

   assign wr_conflict  = wr_conflict_q;
   assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_vliw_multiport_regfile.sv
// tb/tb_vliw_multiport_regfile.sv - directed self-checking bench for vliw_multiport_regfile

module tb_vliw_multiport_regfile;

   logic         clk = 1'b0;
   logic         reset;
   logic [1:0]   wr_en;
   logic [1:0]   s_wr_en;
   logic [9:0]   wr_addr;
   logic [63:0]  wr_data;
   logic [19:0]  rd_addr;
   logic [127:0] rd_data;
   logic [127:0] s_rd_data;
   logic         wr_conflict;
   logic         s_conflict;
   logic [15:0]  conflict_cnt;
   logic [1:0]   s_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   vliw_multiport_regfile dut (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data),
      .wr_conflict  (wr_conflict),
      .conflict_cnt (conflict_cnt)
   );

   vliw_multiport_regfile #(.CNT_W(2)) dut_sat (
      .clk          (clk),
      .reset        (reset),
      .wr_en        (s_wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .rd_addr      (rd_addr),
      .rd_data      (s_rd_data),
      .wr_conflict  (s_conflict),
      .conflict_cnt (s_cnt)
   );

   function automatic logic [31:0] rd(input int r);
      return rd_data[r*32 +: 32];
   endfunction

   task automatic set_wr(input int p, input logic [4:0] a, input logic [31:0] d);
      wr_addr[p*5 +: 5]  = a;
      wr_data[p*32 +: 32] = d;
   endtask

   task automatic set_rd(input int r, input logic [4:0] a);
      rd_addr[r*5 +: 5] = a;
   endtask

   // Drive at posedge, commit at the following negedge, sample 1 time unit later.
   task automatic commit_edge();
      @(negedge clk);
      #1;
   endtask

   task automatic test_reset();
      @(posedge clk);
      reset = 1'b1; wr_en = 2'b00; s_wr_en = 2'b00;
      wr_addr = '0; wr_data = '0; rd_addr = '0;
      commit_edge();
      commit_edge();
      for (int r = 0; r < 4; r++) set_rd(r, 5'(r + 9));
      #1;
      for (int r = 0; r < 4; r++) begin
         n_cmp++;
         if (rd(r) !== 32'h0) begin
            n_bad++;
            $display("FAIL reset_held_rd%0d: got %h want 00000000", r, rd(r));
         end
      end
      @(posedge clk);
      reset = 1'b0;
      for (int g = 0; g < 8; g++) begin
         for (int r = 0; r < 4; r++) set_rd(r, 5'(g*4 + r));
         #1;
         for (int r = 0; r < 4; r++) begin
            n_cmp++;
            if (rd(r) !== 32'h0) begin
               n_bad++;
               $display("FAIL reset_reg%0d: got %h want 00000000", g*4 + r, rd(r));
            end
         end
      end
      n_cmp++;
      if (wr_conflict !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_conflict: got %b want 0", wr_conflict);
      end
      n_cmp++;
      if (conflict_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_cnt: got %0d want 0", conflict_cnt);
      end
      n_cmp++;
      if (s_cnt !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_sat_cnt: got %0d want 0", s_cnt);
      end
   endtask

   task automatic test_single_write();
      @(posedge clk);
      wr_en = 2'b01;
      set_wr(0, 5'd5, 32'hDEADBEEF);
      set_wr(1, 5'd6, 32'h12345678);
      commit_edge();
      @(posedge clk);
      wr_en = 2'b00;
      set_rd(0, 5'd5);
      #1;
      n_cmp++;
      if (rd(0) !== 32'hDEADBEEF) begin
         n_bad++;
         $display("FAIL single_write_reg5: got %h want deadbeef", rd(0));
      end
      for (int g = 0; g < 8; g++) begin
         for (int r = 0; r < 4; r++) set_rd(r, 5'(g*4 + r));
         #1;
         for (int r = 0; r < 4; r++) begin
            if (g*4 + r != 5) begin
               n_cmp++;
               if (rd(r) !== 32'h0) begin
                  n_bad++;
                  $display("FAIL single_write_other%0d: got %h want 00000000", g*4 + r, rd(r));
               end
            end
         end
      end
      n_cmp++;
      if (wr_conflict !== 1'b0) begin
         n_bad++;
         $display("FAIL single_write_conflict: got %b want 0", wr_conflict);
      end
   endtask

   task automatic test_conflict();
      @(posedge clk);
      wr_en = 2'b11;
      set_wr(0, 5'd7, 32'h11111111);
      set_wr(1, 5'd7, 32'h22222222);
      commit_edge();
      @(posedge clk);
      wr_en = 2'b00;
      set_rd(1, 5'd7);
      #1;
      n_cmp++;
      if (rd(1) !== 32'h22222222) begin
         n_bad++;
         $display("FAIL conflict_winner: got %h want 22222222", rd(1));
      end
      n_cmp++;
      if (wr_conflict !== 1'b1) begin
         n_bad++;
         $display("FAIL conflict_flag: got %b want 1", wr_conflict);
      end
      n_cmp++;
      if (conflict_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL conflict_cnt: got %0d want 1", conflict_cnt);
      end
      commit_edge();
      n_cmp++;
      if (wr_conflict !== 1'b0) begin
         n_bad++;
         $display("FAIL conflict_clear: got %b want 0", wr_conflict);
      end
      n_cmp++;
      if (conflict_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL conflict_cnt_hold: got %0d want 1", conflict_cnt);
      end
   endtask

   task automatic test_zero_reg();
      @(posedge clk);
      wr_en = 2'b11;
      set_wr(0, 5'd0, 32'hFFFFFFFF);
      set_wr(1, 5'd0, 32'hFFFFFFFF);
      set_rd(2, 5'd0);
      #1;
      n_cmp++;
      if (rd(2) !== 32'h0) begin
         n_bad++;
         $display("FAIL zero_reg_same_cycle: got %h want 00000000", rd(2));
      end
      commit_edge();
      @(posedge clk);
      wr_en = 2'b00;
      #1;
      n_cmp++;
      if (rd(2) !== 32'h0) begin
         n_bad++;
         $display("FAIL zero_reg_read: got %h want 00000000", rd(2));
      end
      n_cmp++;
      if (wr_conflict !== 1'b0) begin
         n_bad++;
         $display("FAIL zero_reg_conflict: got %b want 0", wr_conflict);
      end
      n_cmp++;
      if (conflict_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL zero_reg_cnt: got %0d want 1", conflict_cnt);
      end
   endtask

   task automatic test_distinct_ports();
      // Two ports, two registers: both land, no conflict.
      @(posedge clk);
      wr_en = 2'b11;
      set_wr(0, 5'd3, 32'hAAAA0003);
      set_wr(1, 5'd4, 32'hBBBB0004);
      commit_edge();
      // Port 1 aims at reg 3 but is disabled: it must neither win nor conflict.
      @(posedge clk);
      wr_en = 2'b01;
      set_wr(0, 5'd3, 32'hCCCC0003);
      set_wr(1, 5'd3, 32'hDEAD0000);
      commit_edge();
      @(posedge clk);
      wr_en = 2'b00;
      set_rd(0, 5'd3);
      set_rd(1, 5'd4);
      #1;
      n_cmp++;
      if (rd(0) !== 32'hCCCC0003) begin
         n_bad++;
         $display("FAIL distinct_reg3: got %h want cccc0003", rd(0));
      end
      n_cmp++;
      if (rd(1) !== 32'hBBBB0004) begin
         n_bad++;
         $display("FAIL distinct_reg4: got %h want bbbb0004", rd(1));
      end
      n_cmp++;
      if (wr_conflict !== 1'b0) begin
         n_bad++;
         $display("FAIL distinct_conflict: got %b want 0", wr_conflict);
      end
      n_cmp++;
      if (conflict_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL distinct_cnt: got %0d want 1", conflict_cnt);
      end
   endtask

   task automatic test_saturation();
      logic [1:0] want [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      @(posedge clk);
      wr_en = 2'b00;
      s_wr_en = 2'b11;
      set_wr(0, 5'd2, 32'h00000020);
      set_wr(1, 5'd2, 32'h00000021);
      for (int i = 0; i < 5; i++) begin
         commit_edge();
         n_cmp++;
         if (s_cnt !== want[i]) begin
            n_bad++;
            $display("FAIL sat_cnt_edge%0d: got %0d want %0d", i + 1, s_cnt, want[i]);
         end
         n_cmp++;
         if (s_conflict !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_flag_edge%0d: got %b want 1", i + 1, s_conflict);
         end
      end
      @(posedge clk);
      s_wr_en = 2'b00;
      n_cmp++;
      if (conflict_cnt !== 16'd1) begin
         n_bad++;
         $display("FAIL sat_main_untouched: got %0d want 1", conflict_cnt);
      end
   endtask

   task automatic test_back_to_back();
      @(posedge clk);
      wr_en = 2'b01;
      set_wr(0, 5'd9, 32'h0000000A);
      commit_edge();
      @(posedge clk);
      wr_en = 2'b01;
      set_wr(0, 5'd9, 32'h0000000B);
      for (int r = 0; r < 4; r++) set_rd(r, 5'd9);
      #1;
      n_cmp++;
`ifdef REGFILE_BYPASS_EN
      if (rd(0) !== 32'h0000000B) begin
         n_bad++;
         $display("FAIL bypass_before_edge: got %h want 0000000b", rd(0));
      end
`else
      if (rd(0) !== 32'h0000000A) begin
         n_bad++;
         $display("FAIL bypass_before_edge: got %h want 0000000a", rd(0));
      end
`endif
      commit_edge();
      @(posedge clk);
      wr_en = 2'b00;
      #1;
      for (int r = 0; r < 4; r++) begin
         n_cmp++;
         if (rd(r) !== 32'h0000000B) begin
            n_bad++;
            $display("FAIL alias_after_edge_rd%0d: got %h want 0000000b", r, rd(r));
         end
      end
      // Reset wins over a write on the same edge.
      @(posedge clk);
      reset = 1'b1;
      wr_en = 2'b01;
      set_wr(0, 5'd9, 32'h0000000C);
      commit_edge();
      n_cmp++;
      if (rd(0) !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mid_write_held: got %h want 00000000", rd(0));
      end
      @(posedge clk);
      reset = 1'b0;
      wr_en = 2'b00;
      set_rd(1, 5'd7);
      #1;
      n_cmp++;
      if (rd(0) !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mid_write_reg9: got %h want 00000000", rd(0));
      end
      n_cmp++;
      if (rd(1) !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_mid_write_reg7: got %h want 00000000", rd(1));
      end
      n_cmp++;
      if (conflict_cnt !== 16'd0) begin
         n_bad++;
         $display("FAIL reset_mid_write_cnt: got %0d want 0", conflict_cnt);
      end
      n_cmp++;
      if (s_cnt !== 2'd0) begin
         n_bad++;
         $display("FAIL reset_mid_write_sat_cnt: got %0d want 0", s_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_conflict();
      test_zero_reg();
      test_distinct_ports();
      test_saturation();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
